// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - CPU/DMA arbiter for a single-port SRAM with starvation-limited DMA forcing
//
// Purpose:
//   Shares one synchronous single-port SRAM between a CPU controller (default
//   priority) and a DMA engine. DMA is served in CPU-idle cycles, or forced in
//   when it has been refused MAX_WAIT consecutive cycles, in which case the
//   CPU is stalled for that one cycle. Read data (one cycle latency) is routed
//   back to whichever requester issued the read.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   cpu_en/we/addr/di       CPU access request (held by the CPU while stalled)
//   cpu_do, cpu_stall       CPU read data (held until next CPU read), refusal
//   dma_req/we/addr/di      DMA access request (held until dma_ack)
//   dma_ack                 DMA access issued this cycle
//   dma_do, dma_valid       DMA read data and its one-cycle valid pulse
//   sram_ADDR/DI/EN/WE      SRAM command side
//   sram_DO                 SRAM read data, valid the cycle after a read issue

module sram_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_en,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_di,
    output logic [DATA_W-1:0] cpu_do,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_di,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_do,
    output logic              dma_valid,

    output logic [ADDR_W-1:0] sram_ADDR,
    output logic [DATA_W-1:0] sram_DI,
    output logic              sram_EN,
    output logic              sram_WE,
    input  logic [DATA_W-1:0] sram_DO
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0]        wait_cnt;
    logic [7:0]        wait_cnt_nxt;
    owner_t            rd_owner;
    owner_t            rd_owner_nxt;
    logic [DATA_W-1:0] cpu_do_q;
    logic [DATA_W-1:0] dma_do_q;

    logic force_dma;
    logic grant_cpu;
    logic grant_dma;

    // Grant decision: a starved DMA request overrides the CPU for one cycle.
    always_comb begin
        force_dma = dma_req && (wait_cnt == WAIT_LIM);
        grant_dma = force_dma || (!cpu_en && dma_req);
        grant_cpu = cpu_en && !force_dma;
    end

    // SRAM command mux and handshake outputs. Everything combinational is
    // held at zero while reset is low so the SRAM sees no access during reset.
    always_comb begin
        sram_EN   = 1'b0;
        sram_WE   = 1'b0;
        sram_ADDR = '0;
        sram_DI   = '0;
        dma_ack   = 1'b0;
        cpu_stall = 1'b0;
        if (reset) begin
            if (grant_dma) begin
                sram_EN   = 1'b1;
                sram_WE   = dma_we;
                sram_ADDR = dma_addr;
                sram_DI   = dma_di;
                dma_ack   = 1'b1;
            end else if (grant_cpu) begin
                sram_EN   = 1'b1;
                sram_WE   = cpu_we;
                sram_ADDR = cpu_addr;
                sram_DI   = cpu_di;
            end
            cpu_stall = force_dma && cpu_en;
        end
    end

    // Starvation counter: counts consecutive refusals of a pending DMA
    // request; any grant or withdrawal starts it over.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (grant_dma || !dma_req) begin
            wait_cnt_nxt = 8'd0;
        end else if (wait_cnt < WAIT_LIM) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end
    end

    // Tag the issued read with its owner so the return one cycle later is
    // steered correctly even when reads from both sides alternate.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (grant_dma && !dma_we) begin
            rd_owner_nxt = OWN_DMA;
        end else if (grant_cpu && !cpu_we) begin
            rd_owner_nxt = OWN_CPU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
            rd_owner <= OWN_NONE;
            cpu_do_q <= '0;
            dma_do_q <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            rd_owner <= rd_owner_nxt;
            if (rd_owner == OWN_CPU) begin
                cpu_do_q <= sram_DO;
            end
            if (rd_owner == OWN_DMA) begin
                dma_do_q <= sram_DO;
            end
        end
    end

    // Return path: during the return cycle the requester sees sram_DO
    // directly, afterwards the captured copy keeps the value stable.
    // rd_owner is forced to NONE by reset, so a read in flight is discarded.
    always_comb begin
        cpu_do    = (rd_owner == OWN_CPU) ? sram_DO : cpu_do_q;
        dma_do    = (rd_owner == OWN_DMA) ? sram_DO : dma_do_q;
        dma_valid = (rd_owner == OWN_DMA);
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic              clk;
    logic              reset;
    logic              cpu_en, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_di, cpu_do;
    logic              cpu_stall;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_di, dma_do;
    logic              dma_ack, dma_valid;
    logic [ADDR_W-1:0] sram_ADDR;
    logic [DATA_W-1:0] sram_DI, sram_DO;
    logic              sram_EN, sram_WE;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
        .cpu_do(cpu_do), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_di(dma_di),
        .dma_ack(dma_ack), .dma_do(dma_do), .dma_valid(dma_valid),
        .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
        .sram_DO(sram_DO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM device: 256 words, read data registered at the issue edge.
    logic [DATA_W-1:0] smem [256];
    always @(posedge clk) begin
        if (sram_EN) begin
            if (sram_WE) smem[sram_ADDR[7:0]] <= sram_DI;
            else         sram_DO <= smem[sram_ADDR[7:0]];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the arbiter should do, in terms of requests,
    // refusal counts and a list of returns owed to each requester.
    logic [DATA_W-1:0] mmem [256];
    int                m_wait;
    int                ret_owner;     // 0 none, 1 cpu, 2 dma
    logic [DATA_W-1:0] ret_data;
    logic [DATA_W-1:0] cpu_hold, dma_hold;
    logic              exp_ack, exp_stall;
    logic              seen_ack;

    task automatic model_reset();
        m_wait    = 0;
        ret_owner = 0;
        ret_data  = '0;
        cpu_hold  = '0;
        dma_hold  = '0;
        exp_ack   = 1'b0;
        exp_stall = 1'b0;
    endtask

    // Check one cycle at the falling edge, advance the model, return just
    // after the next rising edge so the caller can drive the next cycle.
    task automatic step();
        logic        use_dma, use_cpu, e_en, e_we;
        logic [15:0] e_addr;
        logic [31:0] e_di;
        @(negedge clk);
        use_dma = dma_req && ((m_wait == MAX_WAIT) || !cpu_en);
        use_cpu = cpu_en && !use_dma;
        exp_ack   = use_dma;
        exp_stall = cpu_en && use_dma;
        e_en   = use_dma || use_cpu;
        e_we   = use_dma ? dma_we : (use_cpu ? cpu_we : 1'b0);
        e_addr = use_dma ? dma_addr : cpu_addr;
        e_di   = use_dma ? dma_di : cpu_di;

        check("sram_en", 32'(sram_EN), 32'(e_en));
        check("sram_we", 32'(sram_WE), 32'(e_we));
        check("dma_ack", 32'(dma_ack), 32'(exp_ack));
        check("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        if (e_en) check("sram_addr", 32'(sram_ADDR), 32'(e_addr));
        if (e_en && e_we) check("sram_di", sram_DI, e_di);
        check("dma_valid", 32'(dma_valid), 32'(ret_owner == 2));
        check("dma_do", dma_do, (ret_owner == 2) ? ret_data : dma_hold);
        check("cpu_do", cpu_do, (ret_owner == 1) ? ret_data : cpu_hold);
        seen_ack = dma_ack;

        if (ret_owner == 1) cpu_hold = ret_data;
        if (ret_owner == 2) dma_hold = ret_data;
        if (use_dma || !dma_req)  m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        ret_owner = 0;
        if (e_en) begin
            if (e_we) mmem[e_addr[7:0]] = e_di;
            else begin
                ret_owner = use_dma ? 2 : 1;
                ret_data  = mmem[e_addr[7:0]];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_en = 0; cpu_we = 0; cpu_addr = '0; cpu_di = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_di = '0;
    endtask

    task automatic set_mem(input int a, input logic [31:0] d);
        smem[a] = d;
        mmem[a] = d;
    endtask

    int n;

    initial begin
        idle();
        for (int i = 0; i < 256; i++) set_mem(i, $urandom);
        sram_DO = '0;
        model_reset();

        // Reset with both requesters active: everything must read zero.
        reset = 1'b0;
        cpu_en = 1; cpu_addr = 16'h5; dma_req = 1; dma_addr = 16'h6;
        #12;
        check("rst_en", 32'(sram_EN), 0);
        check("rst_ack", 32'(dma_ack), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_addr", 32'(sram_ADDR), 0);
        check("rst_cpu_do", cpu_do, 0);
        check("rst_dma_do", dma_do, 0);
        check("rst_valid", 32'(dma_valid), 0);
        @(posedge clk); #1;
        idle();
        reset = 1'b1;
        step();

        // CPU write then read back.
        cpu_en = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_di = 32'hDEADBEEF;
        step();
        cpu_we = 0;
        step();
        idle();
        check("cpu_rdback", cpu_do, 32'hDEADBEEF);
        step();
        check("cpu_hold", cpu_do, 32'hDEADBEEF);

        // DMA read with CPU idle.
        set_mem(16'h20, 32'h12345678);
        dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
        step();
        check("dma_ack_seen", 32'(seen_ack), 1);
        idle();
        check("dma_valid_ret", 32'(dma_valid), 1);
        check("dma_rd", dma_do, 32'h12345678);
        step();

        // Starvation: CPU busy every cycle, DMA forced on the 9th cycle; twice
        // in a row shows the counter restarting from zero.
        for (int r = 0; r < 2; r++) begin
            n = 0;
            cpu_en = 1; cpu_we = 0; cpu_addr = 16'h3;
            dma_req = 1; dma_we = 1; dma_addr = 16'h4; dma_di = 32'hA5A50000 + r;
            seen_ack = 0;
            while (!seen_ack && n < 20) begin
                step();
                n++;
            end
            check("starve_cycles", 32'(n), 32'(MAX_WAIT + 1));
            dma_req = 0;
            step();
        end
        idle();
        step();

        // Alternating CPU / DMA reads on consecutive cycles.
        cpu_en = 1; cpu_we = 0; cpu_addr = 16'h1;
        step();
        idle();
        dma_req = 1; dma_addr = 16'h2;
        check("alt_cpu_do", cpu_do, mmem[1]);
        check("alt_no_valid", 32'(dma_valid), 0);
        step();
        idle();
        check("alt_dma_do", dma_do, mmem[2]);
        check("alt_dma_valid", 32'(dma_valid), 1);
        check("alt_cpu_keep", cpu_do, mmem[1]);
        step();

        // Reset asserted during the return cycle of a DMA read.
        dma_req = 1; dma_addr = 16'h7;
        step();
        idle();
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(dma_valid), 0);
        check("midrst_dma_do", dma_do, 0);
        check("midrst_cpu_do", cpu_do, 0);
        @(negedge clk);
        check("midrst_valid2", 32'(dma_valid), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        step();
        check("post_rst_valid", 32'(dma_valid), 0);

        // Randomized traffic obeying both request protocols.
        for (int c = 0; c < 3000; c++) begin
            if (!exp_stall) begin
                cpu_en   = ($urandom_range(0, 99) < 60);
                cpu_we   = $urandom_range(0, 1);
                cpu_addr = 16'($urandom_range(0, 15));
                cpu_di   = $urandom;
            end
            if (dma_req && !exp_ack && ($urandom_range(0, 99) < 95)) begin
                // keep holding the pending request
            end else begin
                dma_req  = ($urandom_range(0, 99) < 50);
                dma_we   = $urandom_range(0, 1);
                dma_addr = 16'($urandom_range(0, 15));
                dma_di   = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Single-port SRAM responder. The CPU controller and the DMA engine share the one SRAM port through this block. The CPU has default priority. The DMA is served in idle CPU cycles, or forcibly once its starvation limit is reached, in which case the CPU is stalled for one cycle. Read data is routed back to whichever requester issued the read.

Parameters:
ADDR_W, 16, SRAM word-address width
DATA_W, 32, SRAM data width
MAX_WAIT, 8, consecutive cycles a pending DMA request may be refused before it is force-granted (range 1..255)

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
cpu_en  input  1  CPU access request this cycle
cpu_we  input  1  CPU write (1) / read (0)
cpu_addr  input  ADDR_W  CPU word address
cpu_di  input  DATA_W  CPU write data
cpu_do  output  DATA_W  CPU read data
cpu_stall  output  1  CPU access refused this cycle; CPU must hold its request and retry
dma_req  input  1  DMA access request; held until dma_ack
dma_we  input  1  DMA write / read
dma_addr  input  ADDR_W  DMA word address
dma_di  input  DATA_W  DMA write data
dma_ack  output  1  one-cycle pulse: DMA request issued to SRAM this cycle
dma_do  output  DATA_W  DMA read data
dma_valid  output  1  one-cycle pulse: dma_do valid
sram_ADDR  output  ADDR_W  to SRAM
sram_DI  output  DATA_W  to SRAM
sram_EN  output  1  to SRAM
sram_WE  output  1  to SRAM
sram_DO  input  DATA_W  from SRAM; valid the cycle after a read is issued

Behaviour:
- Reset (reset=0, async): wait_cnt=0, rd_owner=NONE, and cpu_do, dma_do, dma_valid, dma_ack, cpu_stall are all 0. Combinational SRAM outputs are 0 while reset is low.
- Grant decision is combinational each cycle:
  - force = dma_req && (wait_cnt == MAX_WAIT).
  - force: grant DMA. cpu_stall = cpu_en.
  - else cpu_en: grant CPU. cpu_stall = 0.
  - else dma_req: grant DMA.
  - else: no grant. sram_EN=0 and sram_WE=0.
- Granted requester drives sram_ADDR, sram_DI and sram_WE. sram_EN=1.
- dma_ack = DMA granted (combinational, same cycle).
- wait_cnt (8 bit, registered):
  - cleared when DMA is granted or dma_req=0;
  - otherwise incremented when dma_req=1 and DMA is refused;
  - saturates at MAX_WAIT.
- Read return pipeline, rd_owner register ∈ {NONE, CPU, DMA}:
  - set to the granted requester when the issued access is a read; else NONE.
  - Cycle after issue, rd_owner=CPU: cpu_do <= sram_DO is captured into a register that holds its value until the next CPU read.
  - Cycle after issue, rd_owner=DMA: dma_do is driven from sram_DO (held registered afterwards) and dma_valid=1 for exactly one cycle.
  - Read latency: 1 cycle from issue to data.
- Writes produce no return pulse. A write is complete at the issue edge.
- Back-to-back reads from alternating owners are legal, one per cycle. The rd_owner pipeline keeps them separate.
- Same address on CPU and DMA in one cycle: only the granted requester accesses it. No merging.
- Reset asserted mid-read: return discarded, dma_valid never pulses, the DMA must re-request.
- dma_req dropping before ack: the request is withdrawn silently and wait_cnt clears.
- Throughput: exactly one SRAM access per cycle maximum. No buffering of requests.

Test Plan:
- Reset, both idle -> sram_EN=0, dma_ack=0, cpu_stall=0, cpu_do=0, dma_do=0.
- CPU write 0xDEADBEEF @0x0010, next cycle CPU read @0x0010 -> sram_EN=1 in both cycles; cpu_do=0xDEADBEEF one cycle after the read issue.
- DMA read @0x0020 (mem=0x12345678), CPU idle -> dma_ack in issue cycle; next cycle dma_valid=1, dma_do=0x12345678.
- CPU requests every cycle, dma_req held, MAX_WAIT=8:
  - 8 refused cycles, then the 9th cycle has dma_ack=1 and cpu_stall=1 (CPU held, retried next cycle);
  - wait_cnt returns to 0.
- Alternating CPU read @A=0x1 / DMA read @B=0x2 issued on consecutive cycles -> cpu_do=mem[1] and dma_do=mem[2], each exactly one cycle after its own issue; no crossover.
- reset pulsed low the cycle after a DMA read issue -> dma_valid stays 0, all outputs 0 immediately (async), normal operation after release.
